zseq: RTL and testbench
=======================

# zseq

Instruction sequencer sitting directly upstream of the 4x8 register file (`register`): accepts 8-bit instruction bytes over a valid/ready stream, decodes them, and drives the register file's `IN`/`OPCODE`/`REG_SEL` inputs while consuming its `OUT` read data. It performs load-immediate, move, add and output-to-port operations. It is the first sequential control stage of the Zephyr datapath.

## Interface
- No parameters: data width 8, register count 4, both fixed.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `INSTR`  in  8  instruction byte or immediate byte.
- `INSTR_VALID`  in  1  `INSTR` holds a byte.
- `INSTR_READY`  out  1  sequencer accepts a byte this cycle.
- `RF_IN`  out  8  write data to register file; always equals accumulator `A`.
- `RF_OPCODE`  out  1  1 = write, 0 = read.
- `RF_SEL`  out  2  register select.
- `RF_OUT`  in  8  register-file read data, combinational from `RF_SEL`.
- `RES`  out  8  result byte from an OUT instruction.
- `RES_VALID`  out  1  `RES` is valid.
- `RES_READY`  in  1  downstream accepts `RES`.
- `BUSY`  out  1  high in every state except FETCH.
- `CARRY`  out  1  carry from the last ADD; see Configuration.

## Operation
- Encoding: `[7:6]` op, `[5:4]` rd, `[3:2]` rs, `[1:0]` reserved and ignored.
- Ops: 00 LDI (next stream byte → rd), 01 MOV (rd ← rs), 10 ADD (rd ← rd + rs, mod 256), 11 OUT (`RES` ← rd).
- Registers: `IR[7:0]`, accumulator `A[7:0]`, `CARRY`, `state`.
- States and transitions:
  - FETCH: `INSTR_READY`=1. On handshake, `IR` ← `INSTR`. Next state: LDI→IMM, MOV→RDS, ADD→RDD, OUT→RDD.
  - IMM: `INSTR_READY`=1. On handshake, `A` ← `INSTR`, then WB. Without a byte, wait.
  - RDD: `RF_SEL`=rd, `A` ← `RF_OUT`. ADD→RDS; OUT→EMIT.
  - RDS: `RF_SEL`=rs. MOV: `A` ← `RF_OUT`. ADD: `{CARRY,A}` ← `A + RF_OUT` (9-bit sum). Then WB.
  - WB: `RF_SEL`=rd, `RF_OPCODE`=1 for exactly one cycle, then FETCH.
  - EMIT: `RES_VALID`=1, `RES`=`A`. On `RES_READY`, go to FETCH.
- `RF_OPCODE`=0 in every state except WB.
- `RF_SEL`=0 in FETCH, IMM and EMIT.
- Same-register cases (`rd`=`rs`) need no special handling: ADD R2,R2 doubles R2.

## Timing
- Reset, asynchronous: state=FETCH; `IR`, `A`, `CARRY`, `RES` = 0; `RES_VALID`=0; `RF_OPCODE`=0; `RF_SEL`=0.
- `INSTR_READY` is forced 0 while `RST_N`=0 and is 1 in the first cycle after release.
- Reset mid-instruction aborts it with no register-file write. Register-file contents are not cleared by this block.
- Minimum cycles from instruction handshake back to FETCH:
  - LDI: 2 (IMM, WB), plus any immediate-byte stall.
  - MOV: 2 (RDS, WB).
  - ADD: 3 (RDD, RDS, WB).
  - OUT: 2 (RDD, EMIT), plus any `RES_READY` stall.
- Back-to-back: the next instruction is accepted in the FETCH cycle right after WB or the EMIT handshake. No overlap between instructions.
- Outputs are registered or decoded from registered state only. `RF_SEL` and `RF_IN` are stable for the whole WB cycle.
- EMIT holds `RES` and `RES_VALID` stable until `RES_READY`. `RES_VALID` drops in the cycle after the handshake.
- `INSTR_VALID` is ignored in RDD, RDS, WB and EMIT. The byte is not consumed.

## Configuration
- `ZSEQ_CARRY_EN` defined: ADD updates `CARRY` with bit 8 of the sum. `CARRY` holds its value through other instructions and resets to 0.
- `ZSEQ_CARRY_EN` undefined: no carry flop is built, `CARRY` is tied to 0, and ADD uses an 8-bit wrap sum.

## Test plan
Bench instantiates `zseq` with the real `register` file; the macro is defined unless stated.
- Reset, then stream 0x00,0xAA / 0x10,0xCC / 0x20,0xF0 / 0x30,0x0F → R0..R3 = 0xAA, 0xCC, 0xF0, 0x0F. Each WB has `RF_OPCODE`=1 for exactly 1 cycle.
- With R0=0xAA and R1=0xCC, send ADD 0x84 then OUT 0xC0 → `RES`=0x76, `CARRY`=1. Without the macro: `RES`=0x76 and `CARRY`=0.
- MOV 0x74, then OUT 0xF0 with `RES_READY` held low 5 cycles → `RES`=0xCC held stable. `RES_VALID` drops 1 cycle after `RES_READY` rises.
- LDI 0x20 with the immediate delayed 4 cycles (`INSTR_VALID` low) → `INSTR_READY` stays 1 in IMM and R2 = the immediate. No early write.
- Assert `RST_N`=0 during RDS of an ADD → `RF_OPCODE` never goes 1, rd is unchanged, `INSTR_READY`=0 during reset and 1 after release.
- ADD R2,R2 with R2=0x80 → R2=0x00 and `CARRY`=1. A following `RES` from OUT 0xE0 is 0x00.

Source files
------------

// File: rtl/zseq_if.sv
// zseq_if: instruction stream, register-file port and result stream of the
// zseq instruction sequencer.
// master: the sequencer side. slave: the environment side (instruction
// source, register file and result sink).
interface zseq_if;
  logic [7:0] INSTR;
  logic       INSTR_VALID;
  logic       INSTR_READY;
  logic [7:0] RF_IN;
  logic       RF_OPCODE;
  logic [1:0] RF_SEL;
  logic [7:0] RF_OUT;
  logic [7:0] RES;
  logic       RES_VALID;
  logic       RES_READY;
  logic       BUSY;
  logic       CARRY;

  modport master (
    input  INSTR, INSTR_VALID, RF_OUT, RES_READY,
    output INSTR_READY, RF_IN, RF_OPCODE, RF_SEL, RES, RES_VALID, BUSY, CARRY
  );

  modport slave (
    output INSTR, INSTR_VALID, RF_OUT, RES_READY,
    input  INSTR_READY, RF_IN, RF_OPCODE, RF_SEL, RES, RES_VALID, BUSY, CARRY
  );
endinterface

// File: rtl/zseq.sv
// zseq: instruction sequencer in front of the 4x8 register file.
// It decodes LDI / MOV / ADD / OUT bytes from a valid/ready stream and drives
// the register file through RF_IN / RF_OPCODE / RF_SEL.
// Optional feature macro: ZSEQ_CARRY_EN. When it is defined, ADD records bit 8
// of its sum in CARRY. When it is undefined, no carry flop exists and CARRY
// is tied to 0.
module zseq (
  input  logic   CLK,
  input  logic   RST_N,
  zseq_if.master bus
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_IMM   = 3'd1,
    ST_RDD   = 3'd2,
    ST_RDS   = 3'd3,
    ST_WB    = 3'd4,
    ST_EMIT  = 3'd5
  } state_t;

  localparam logic [1:0] OP_LDI = 2'd0;
  localparam logic [1:0] OP_MOV = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_OUT = 2'd3;

  state_t     state_r;
  state_t     state_next_s;
  logic [7:2] ir_r;          // the reserved bits [1:0] are never stored
  logic [7:0] a_r;
  logic [7:0] res_r;
  logic [1:0] op_s;
  logic [1:0] rd_s;
  logic [1:0] rs_s;
  logic [7:0] add_s;
  logic       ready_s;
  logic       instr_hs_s;
  logic [1:0] sel_s;
  logic       opcode_s;
  logic       res_valid_s;
  logic       unused_s;

  assign op_s = ir_r[7:6];
  assign rd_s = ir_r[5:4];
  assign rs_s = ir_r[3:2];

  // The reserved instruction bits carry no meaning.
  assign unused_s = ^bus.INSTR[1:0];

  // Ready is gated by RST_N so that it reads 0 for the whole reset.
  assign instr_hs_s = bus.INSTR_VALID & ready_s & RST_N;

`ifdef ZSEQ_CARRY_EN
  logic carry_s;
  logic carry_r;

  assign {carry_s, add_s} = {1'b0, a_r} + {1'b0, bus.RF_OUT};

  // The carry flag is updated by ADD only and holds through all other instructions.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      carry_r <= 1'b0;
    end else if (state_r == ST_RDS && op_s == OP_ADD) begin
      carry_r <= carry_s;
    end else begin
      carry_r <= carry_r;
    end
  end

  assign bus.CARRY = carry_r;
`else
  assign add_s     = a_r + bus.RF_OUT;
  assign bus.CARRY = 1'b0;
`endif

  // State register. Reset aborts any instruction in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode. FETCH decodes the incoming byte because IR is still loading.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (instr_hs_s) begin
          case (bus.INSTR[7:6])
            OP_LDI:  state_next_s = ST_IMM;
            OP_MOV:  state_next_s = ST_RDS;
            default: state_next_s = ST_RDD;
          endcase
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_IMM: begin
        if (instr_hs_s) begin
          state_next_s = ST_WB;
        end else begin
          state_next_s = ST_IMM;
        end
      end
      ST_RDD: begin
        if (op_s == OP_ADD) begin
          state_next_s = ST_RDS;
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      ST_RDS:  state_next_s = ST_WB;
      ST_WB:   state_next_s = ST_FETCH;
      ST_EMIT: begin
        if (bus.RES_READY) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      default: state_next_s = ST_FETCH;
    endcase
  end

  // Output decode from registered state only. There is no path from inputs to these outputs.
  always_comb begin
    ready_s     = 1'b0;
    sel_s       = 2'd0;
    opcode_s    = 1'b0;
    res_valid_s = 1'b0;
    case (state_r)
      ST_FETCH: ready_s = 1'b1;
      ST_IMM:   ready_s = 1'b1;
      ST_RDD:   sel_s   = rd_s;
      ST_RDS:   sel_s   = rs_s;
      ST_WB: begin
        sel_s    = rd_s;
        opcode_s = 1'b1;
      end
      ST_EMIT:  res_valid_s = 1'b1;
      default: begin
        ready_s     = 1'b0;
        sel_s       = 2'd0;
        opcode_s    = 1'b0;
        res_valid_s = 1'b0;
      end
    endcase
  end

  // Datapath: instruction register, accumulator and the result byte latched for EMIT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ir_r  <= 6'd0;
      a_r   <= 8'd0;
      res_r <= 8'd0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (instr_hs_s) begin
            ir_r <= bus.INSTR[7:2];
          end else begin
            ir_r <= ir_r;
          end
        end
        ST_IMM: begin
          if (instr_hs_s) begin
            a_r <= bus.INSTR;
          end else begin
            a_r <= a_r;
          end
        end
        ST_RDD: begin
          a_r <= bus.RF_OUT;
          // RES only changes for OUT, so it stays quiet during ADD.
          if (op_s == OP_OUT) begin
            res_r <= bus.RF_OUT;
          end else begin
            res_r <= res_r;
          end
        end
        ST_RDS: begin
          if (op_s == OP_MOV) begin
            a_r <= bus.RF_OUT;
          end else begin
            a_r <= add_s;
          end
        end
        default: begin
          ir_r  <= ir_r;
          a_r   <= a_r;
          res_r <= res_r;
        end
      endcase
    end
  end

  assign bus.INSTR_READY = ready_s & RST_N;
  assign bus.RF_IN       = a_r;
  assign bus.RF_OPCODE   = opcode_s;
  assign bus.RF_SEL      = sel_s;
  assign bus.RES         = res_r;
  assign bus.RES_VALID   = res_valid_s;
  assign bus.BUSY        = (state_r != ST_FETCH);

endmodule

// File: tb/tb_zseq.sv
// tb_zseq: self-checking bench for zseq.
// It contains a behavioural 4x8 register file, a directed vector table, a
// reset-abort sequence and randomized instructions checked against an
// instruction-level reference model.
module tb_zseq;

  logic CLK = 1'b0;
  logic RST_N;

  zseq_if bus();

  zseq dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

`ifdef ZSEQ_CARRY_EN
  localparam bit CARRY_ON = 1'b1;
`else
  localparam bit CARRY_ON = 1'b0;
`endif

  // Register file: synchronous write, combinational read.
  logic [7:0] rf [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int wr_total = 0;

  always @(posedge CLK) begin
    if (bus.RF_OPCODE === 1'b1) begin
      rf[bus.RF_SEL] <= bus.RF_IN;
      wr_total <= wr_total + 1;
    end
  end

  assign bus.RF_OUT = rf[bus.RF_SEL];

  // Reference model state.
  logic [7:0] m_reg [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       m_carry = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h, expected %0h (t=%0t)", tag, nm, got, exp, $time);
    end
  endtask

  // Run one instruction through the DUT and check it against the model.
  // The task must be entered at a negedge with the DUT in FETCH, and it returns at such a point.
  task automatic run_one(input string tag, input logic [7:0] ir, input logic [7:0] imm,
                         input int imm_dly, input int res_dly, output logic [7:0] res_got);
    logic [1:0] op, rd, rs;
    int s, exp_res, exp_cyc, exp_wr;
    int cycles, wr, k, e, guard, lat;
    logic [1:0] wb_sel;
    bit seen, stable;
    op = ir[7:6]; rd = ir[5:4]; rs = ir[3:2];
    exp_res = 0; exp_cyc = 0; exp_wr = 0;
    case (op)
      2'd0: begin m_reg[rd] = imm; exp_cyc = 2 + imm_dly; exp_wr = 1; end
      2'd1: begin m_reg[rd] = m_reg[rs]; exp_cyc = 2; exp_wr = 1; end
      2'd2: begin
        s = int'(m_reg[rd]) + int'(m_reg[rs]);
        m_reg[rd] = 8'(s % 256);
        if (CARRY_ON) m_carry = (s > 255);
        exp_cyc = 3; exp_wr = 1;
      end
      default: begin exp_res = int'(m_reg[rd]); exp_cyc = 2 + res_dly; exp_wr = 0; end
    endcase

    cycles = 0; wr = 0; k = 0; e = 0; wb_sel = 2'd0; seen = 1'b0; stable = 1'b1;
    res_got = 8'h00;
    bus.INSTR = ir; bus.INSTR_VALID = 1'b1; lat = 0;
    while (!(bus.INSTR_READY === 1'b1 && bus.BUSY === 1'b0) && lat < 20) begin
      @(negedge CLK); lat++;
    end
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0; bus.INSTR = 8'h00;
    guard = 0;
    while (bus.BUSY === 1'b1 && guard < 64) begin
      cycles++; guard++;
      if (bus.RF_OPCODE === 1'b1) begin wr++; wb_sel = bus.RF_SEL; end
      if (bus.RES_VALID === 1'b1) begin
        if (!seen) begin res_got = bus.RES; seen = 1'b1; end
        else if (bus.RES !== res_got) stable = 1'b0;
        if (e == res_dly) bus.RES_READY = 1'b1;
        e++;
      end else if (bus.INSTR_READY === 1'b1) begin
        if (k == imm_dly) begin bus.INSTR = imm; bus.INSTR_VALID = 1'b1; end
        k++;
      end else begin
        bus.INSTR_VALID = 1'b0;
        bus.INSTR = 8'h00;
      end
      @(negedge CLK);
    end
    bus.RES_READY = 1'b0; bus.INSTR_VALID = 1'b0; bus.INSTR = 8'h00;

    chk(tag, "fetch_latency", lat, 0);
    chk(tag, "timeout", (guard >= 64) ? 1 : 0, 0);
    chk(tag, "cycles", cycles, exp_cyc);
    chk(tag, "wb_pulses", wr, exp_wr);
    if (exp_wr == 1) chk(tag, "wb_sel", wb_sel, rd);
    chk(tag, "regs", {rf[3], rf[2], rf[1], rf[0]}, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
    chk(tag, "carry", bus.CARRY, m_carry);
    chk(tag, "res_valid_drop", bus.RES_VALID, 1'b0);
    if (op == 2'd3) begin
      chk(tag, "res", res_got, exp_res);
      chk(tag, "res_stable", stable, 1'b1);
    end
  endtask

  typedef struct {
    logic [7:0] ir;
    logic [7:0] imm;
    int         imm_dly;
    int         res_dly;
    logic [7:0] exp_val;   // rd contents afterwards, or RES for OUT
    logic       exp_carry; // value with the carry feature built
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [7:0] res;
    int w0;

    vecs[0]  = '{8'h00, 8'hAA, 0, 0, 8'hAA, 1'b0};
    vecs[1]  = '{8'h10, 8'hCC, 0, 0, 8'hCC, 1'b0};
    vecs[2]  = '{8'h20, 8'hF0, 0, 0, 8'hF0, 1'b0};
    vecs[3]  = '{8'h30, 8'h0F, 0, 0, 8'h0F, 1'b0};
    vecs[4]  = '{8'h84, 8'h00, 0, 0, 8'h76, 1'b1};
    vecs[5]  = '{8'hC0, 8'h00, 0, 0, 8'h76, 1'b1};
    vecs[6]  = '{8'h74, 8'h00, 0, 0, 8'hCC, 1'b1};
    vecs[7]  = '{8'hF0, 8'h00, 0, 5, 8'hCC, 1'b1};
    vecs[8]  = '{8'h20, 8'h80, 4, 0, 8'h80, 1'b1};
    vecs[9]  = '{8'hA8, 8'h00, 0, 0, 8'h00, 1'b1};
    vecs[10] = '{8'hE0, 8'h00, 0, 0, 8'h00, 1'b1};

    RST_N = 1'b0; bus.INSTR = 8'h00; bus.INSTR_VALID = 1'b0; bus.RES_READY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset", "instr_ready", bus.INSTR_READY, 1'b0);
    chk("reset", "outputs", {bus.RES_VALID, bus.RF_OPCODE, bus.RF_SEL, bus.BUSY, bus.CARRY},
        {1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
    chk("reset", "res_rfin", {bus.RES, bus.RF_IN}, 16'h0000);
    RST_N = 1'b1;
    #1;
    chk("reset", "ready_after_release", bus.INSTR_READY, 1'b1);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].ir, vecs[i].imm, vecs[i].imm_dly, vecs[i].res_dly, res);
      if (vecs[i].ir[7:6] == 2'd3) chk($sformatf("vec%0d", i), "table_res", res, vecs[i].exp_val);
      else chk($sformatf("vec%0d", i), "table_rd", rf[vecs[i].ir[5:4]], vecs[i].exp_val);
      chk($sformatf("vec%0d", i), "table_carry", bus.CARRY, vecs[i].exp_carry & CARRY_ON);
    end

    // Reset asserted during the RDS cycle of ADD R1,R0: there must be no write.
    bus.INSTR = 8'h90; bus.INSTR_VALID = 1'b1;
    @(negedge CLK);                  // RDD
    bus.INSTR_VALID = 1'b0; bus.INSTR = 8'h00;
    @(negedge CLK);                  // RDS
    w0 = wr_total;
    RST_N = 1'b0;
    #1;
    chk("rst_mid", "opcode_in_reset", bus.RF_OPCODE, 1'b0);
    chk("rst_mid", "ready_in_reset", bus.INSTR_READY, 1'b0);
    repeat (2) @(negedge CLK);
    chk("rst_mid", "ready_still_low", bus.INSTR_READY, 1'b0);
    RST_N = 1'b1;
    #1;
    chk("rst_mid", "ready_after_release", bus.INSTR_READY, 1'b1);
    chk("rst_mid", "busy_after_release", bus.BUSY, 1'b0);
    chk("rst_mid", "carry_cleared", bus.CARRY, 1'b0);
    m_carry = 1'b0;
    @(negedge CLK);
    chk("rst_mid", "no_write", wr_total, w0);
    chk("rst_mid", "rd_unchanged", rf[1], m_reg[1]);

    // Randomized instructions against the model
    for (int i = 0; i < 150; i++) begin
      logic [7:0] ir, imm;
      ir  = 8'($urandom_range(0, 255));
      imm = 8'($urandom_range(0, 255));
      run_one($sformatf("rnd%0d", i), ir, imm, $urandom_range(0, 3), $urandom_range(0, 3), res);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
